// File: rtl/vend_pkg.sv
// Shared encodings between coin_credit_collector and vending_machine:
// FSM states, coin type codes with their values, and product codes.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_PRESENT = 2'b10,
        ST_REFUND  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        COIN_5  = 2'b00,
        COIN_10 = 2'b01,
        COIN_20 = 2'b10,
        COIN_50 = 2'b11
    } coin_e;

    localparam int unsigned COIN_VAL_5  = 5;
    localparam int unsigned COIN_VAL_10 = 10;
    localparam int unsigned COIN_VAL_20 = 20;
    localparam int unsigned COIN_VAL_50 = 50;

    typedef enum logic [1:0] {
        PROD_CHOC    = 2'b00,
        PROD_ICE     = 2'b01,
        PROD_DRINK   = 2'b10,
        PROD_INVALID = 2'b11
    } prod_e;

endpackage

// File: rtl/coin_decoder.sv
// Combinational map from a 2-bit coin type code to its credit value.
module coin_decoder
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 6
) (
    input  logic [1:0]          i_coin_type,
    output logic [CREDIT_W-1:0] o_value_c
);

    always_comb begin
        o_value_c = '0;
        case (coin_e'(i_coin_type))
            COIN_5:  o_value_c = CREDIT_W'(COIN_VAL_5);
            COIN_10: o_value_c = CREDIT_W'(COIN_VAL_10);
            COIN_20: o_value_c = CREDIT_W'(COIN_VAL_20);
            COIN_50: o_value_c = CREDIT_W'(COIN_VAL_50);
            default: o_value_c = '0;
        endcase
    end

endmodule

// File: rtl/coin_credit_collector.sv
// Coin intake stage ahead of vending_machine: accumulates credit, latches a
// product choice, presents money/select for a fixed window, handles refunds.
module coin_credit_collector
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned MAX_CREDIT  = 63,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel_valid,
    input  logic [1:0]          sel_in,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] money,
    output logic [1:0]          select,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] refund,
    output logic                refund_valid,
    output logic                busy
);

    localparam int unsigned SUM_W  = CREDIT_W + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_e              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_money, w_money_nxt;
    logic [1:0]          r_select, w_select_nxt;
    logic [CREDIT_W-1:0] r_refund, w_refund_nxt;
    logic                r_refund_valid, w_refund_valid_nxt;
    logic                r_coin_reject, w_coin_reject_nxt;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
    logic [HOLD_W-1:0]   r_hold, w_hold_nxt;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [SUM_W-1:0]    w_sum;
    logic                w_fits;
    logic                w_sel_ok;

    coin_decoder #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_decoder (
        .i_coin_type (coin_type),
        .o_value_c   (w_coin_val)
    );

    // One extra bit so an overflowing coin is caught rather than wrapped.
    assign w_sum    = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_fits   = (w_sum <= SUM_W'(MAX_CREDIT));
    assign w_sel_ok = sel_valid && (prod_e'(sel_in) != PROD_INVALID);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_credit_nxt       = r_credit;
        w_money_nxt        = r_money;
        w_select_nxt       = r_select;
        w_refund_nxt       = r_refund;
        w_refund_valid_nxt = 1'b0;
        w_coin_reject_nxt  = 1'b0;
        w_tcnt_nxt         = r_tcnt;
        w_hold_nxt         = r_hold;

        case (r_state)
            ST_IDLE: begin
                if (coin_valid) begin
                    w_credit_nxt = w_coin_val;
                    w_tcnt_nxt   = '0;
                    w_state_nxt  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    w_coin_reject_nxt  = coin_valid;
                    w_refund_nxt       = r_credit;
                    w_refund_valid_nxt = 1'b1;
                    w_credit_nxt       = '0;
                    w_tcnt_nxt         = '0;
                    w_state_nxt        = ST_REFUND;
                end else if (w_sel_ok) begin
                    w_coin_reject_nxt = coin_valid;
                    w_money_nxt       = r_credit;
                    w_select_nxt      = sel_in;
                    w_hold_nxt        = '0;
                    w_tcnt_nxt        = '0;
                    w_state_nxt       = ST_PRESENT;
                end else if (coin_valid && w_fits) begin
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                    w_tcnt_nxt   = '0;
                end else begin
                    // No accepted coin this cycle: reject any overflow, age the timer.
                    w_coin_reject_nxt = coin_valid;
                    if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        w_refund_nxt       = r_credit;
                        w_refund_valid_nxt = 1'b1;
                        w_credit_nxt       = '0;
                        w_tcnt_nxt         = '0;
                        w_state_nxt        = ST_REFUND;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
                end
            end
            ST_PRESENT: begin
                w_coin_reject_nxt = coin_valid;
                if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_money_nxt  = '0;
                    w_select_nxt = PROD_CHOC;
                    w_credit_nxt = '0;
                    w_hold_nxt   = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_REFUND: begin
                w_coin_reject_nxt = coin_valid;
                w_refund_nxt      = '0;
                w_state_nxt       = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_money        <= '0;
            r_select       <= '0;
            r_refund       <= '0;
            r_refund_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_tcnt         <= '0;
            r_hold         <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_money        <= w_money_nxt;
            r_select       <= w_select_nxt;
            r_refund       <= w_refund_nxt;
            r_refund_valid <= w_refund_valid_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
            r_tcnt         <= w_tcnt_nxt;
            r_hold         <= w_hold_nxt;
        end
    end

    assign money        = r_money;
    assign select       = r_select;
    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign refund       = r_refund;
    assign refund_valid = r_refund_valid;
    assign busy         = (r_state == ST_PRESENT) || (r_state == ST_REFUND);

endmodule

// File: tb/tb_coin_credit_collector.sv
// Directed table-driven bench for coin_credit_collector plus hand sequences
// for the inactivity timeout and reset during presentation.
module tb_coin_credit_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_in;
    logic       cancel;
    logic [5:0] money;
    logic [1:0] select;
    logic [5:0] credit;
    logic       coin_reject;
    logic [5:0] refund;
    logic       refund_valid;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    coin_credit_collector dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .sel_valid    (sel_valid),
        .sel_in       (sel_in),
        .cancel       (cancel),
        .money        (money),
        .select       (select),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .refund       (refund),
        .refund_valid (refund_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [1:0] ct;
        logic       sv;
        logic [1:0] si;
        logic       cn;
        logic [5:0] money;
        logic [1:0] select;
        logic [5:0] credit;
        logic       rej;
        logic [5:0] refund;
        logic       rv;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int cv, int ct, int sv, int si, int cn,
                                int m, int s, int c, int rj, int rf, int rv, int b);
        vec_t v;
        v.cv = 1'(cv);  v.ct = 2'(ct);  v.sv = 1'(sv);  v.si = 2'(si);  v.cn = 1'(cn);
        v.money = 6'(m); v.select = 2'(s); v.credit = 6'(c); v.rej = 1'(rj);
        v.refund = 6'(rf); v.rv = 1'(rv); v.busy = 1'(b);
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, vec_t e);
        chk({tag, ".money"},        8'(money),        8'(e.money));
        chk({tag, ".select"},       8'(select),       8'(e.select));
        chk({tag, ".credit"},       8'(credit),       8'(e.credit));
        chk({tag, ".coin_reject"},  8'(coin_reject),  8'(e.rej));
        chk({tag, ".refund"},       8'(refund),       8'(e.refund));
        chk({tag, ".refund_valid"}, 8'(refund_valid), 8'(e.rv));
        chk({tag, ".busy"},         8'(busy),         8'(e.busy));
    endtask

    task automatic drive(logic cv, logic [1:0] ct, logic sv, logic [1:0] si, logic cn);
        coin_valid = cv;
        coin_type  = ct;
        sel_valid  = sv;
        sel_in     = si;
        cancel     = cn;
    endtask

    initial begin
        vec_t z;
        int   early;
        z = mk(0,0,0,0,0, 0,0,0,0,0,0,0);

        // Coin types: 0=5, 1=10, 2=20, 3=50.
        //            cv ct sv si cn  money sel cred rej rfd rv busy
        vq.push_back(mk(1, 1, 0, 0, 0,   0, 0, 10, 0,  0, 0, 0)); // coin 10
        vq.push_back(mk(0, 0, 1, 0, 0,  10, 0, 10, 0,  0, 0, 1)); // sel choc
        vq.push_back(mk(0, 0, 0, 0, 0,  10, 0, 10, 0,  0, 0, 1)); // hold 2
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0)); // back to idle
        vq.push_back(mk(1, 3, 0, 0, 0,   0, 0, 50, 0,  0, 0, 0)); // coin 50
        vq.push_back(mk(1, 1, 0, 0, 0,   0, 0, 60, 0,  0, 0, 0)); // coin 10
        vq.push_back(mk(1, 0, 0, 0, 0,   0, 0, 60, 1,  0, 0, 0)); // 5 -> 65 rejected
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0, 60, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   0, 0,  0, 0, 60, 1, 1)); // cancel
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0));
        vq.push_back(mk(1, 2, 0, 0, 0,   0, 0, 20, 0,  0, 0, 0)); // coin 20
        vq.push_back(mk(1, 2, 0, 0, 0,   0, 0, 40, 0,  0, 0, 0)); // coin 20
        vq.push_back(mk(0, 0, 0, 0, 1,   0, 0,  0, 0, 40, 1, 1)); // cancel
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0,   0, 0, 50, 0,  0, 0, 0)); // coin 50
        vq.push_back(mk(1, 1, 1, 2, 0,  50, 2, 50, 1,  0, 0, 1)); // sel drink + coin
        vq.push_back(mk(0, 0, 0, 0, 0,  50, 2, 50, 0,  0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0,   0, 0,  5, 0,  0, 0, 0)); // coin 5
        vq.push_back(mk(1, 1, 1, 3, 0,   0, 0, 15, 0,  0, 0, 0)); // sel 11 ignored, coin taken
        vq.push_back(mk(0, 0, 1, 3, 0,   0, 0, 15, 0,  0, 0, 0)); // sel 11 alone
        vq.push_back(mk(1, 0, 0, 0, 1,   0, 0,  0, 1, 15, 1, 1)); // cancel + coin
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 0,   0, 0,  0, 0,  0, 0, 0)); // sel in idle
        vq.push_back(mk(0, 0, 0, 0, 1,   0, 0,  0, 0,  0, 0, 0)); // cancel in idle
        vq.push_back(mk(1, 2, 0, 0, 0,   0, 0, 20, 0,  0, 0, 0)); // coin 20
        vq.push_back(mk(0, 0, 1, 1, 0,  20, 1, 20, 0,  0, 0, 1)); // sel ice
        vq.push_back(mk(1, 0, 0, 0, 1,  20, 1, 20, 1,  0, 0, 1)); // coin+cancel in present
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0,   0, 0, 50, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   0, 0,  0, 0, 50, 1, 1)); // cancel
        vq.push_back(mk(1, 2, 0, 0, 0,   0, 0,  0, 1,  0, 0, 0)); // coin during refund
        vq.push_back(mk(0, 0, 0, 0, 0,   0, 0,  0, 0,  0, 0, 0));

        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_outs("reset", z);
        reset = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].cv, vq[i].ct, vq[i].sv, vq[i].si, vq[i].cn);
            @(negedge clk);
            chk_outs($sformatf("v%0d", i), vq[i]);
        end

        // Inactivity timeout: refund on the 255th idle cycle after the coin.
        drive(1, 2, 0, 0, 0);
        @(negedge clk);
        chk("to.coin_credit", 8'(credit), 8'd20);
        drive(0, 0, 0, 0, 0);
        early = 0;
        for (int k = 1; k <= 254; k++) begin
            @(negedge clk);
            if (refund_valid !== 1'b0 || busy !== 1'b0) early++;
        end
        chk("to.early_refund_cycles", 8'(early), 8'd0);
        @(negedge clk);
        chk_outs("to.fire", mk(0,0,0,0,0, 0,0,0,0,20,1,1));
        @(negedge clk);
        chk_outs("to.after", z);

        // Reset asserted mid-presentation aborts with no refund.
        drive(1, 2, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 2, 0);
        @(negedge clk);
        chk_outs("rp.present", mk(0,0,0,0,0, 30,2,30,0,0,0,1));
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 chk_outs("rp.async", z);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_outs("rp.after", z);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk_outs("rp.fresh", mk(0,0,0,0,0, 0,0,5,0,0,0,0));
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
